// File: rtl/svc_fifo_wr_arb_if.sv
// svc_fifo_wr_arb_if: requester valid/ready/last streams plus the shared FIFO write port.
// fifo_w_data is widened by the index width when SVC_FIFO_WR_ARB_TAG_EN is defined.
interface svc_fifo_wr_arb_if #(
    parameter int N_REQ = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_WIDTH = $clog2(N_REQ);
`ifdef SVC_FIFO_WR_ARB_TAG_EN
    localparam int FW = DATA_WIDTH + IDX_WIDTH;
`else
    localparam int FW = DATA_WIDTH;
`endif
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0] req_last;
    logic [N_REQ-1:0] req_ready;
    logic fifo_w_inc;
    logic [FW-1:0] fifo_w_data;
    logic fifo_w_full;
    logic grant_valid;
    logic [IDX_WIDTH-1:0] grant_idx;
    modport master (
        output req_valid, req_data, req_last, fifo_w_full,
        input req_ready, fifo_w_inc, fifo_w_data, grant_valid, grant_idx
    );
    modport slave (
        input req_valid, req_data, req_last, fifo_w_full,
        output req_ready, fifo_w_inc, fifo_w_data, grant_valid, grant_idx
    );
endinterface

// File: rtl/svc_fifo_wr_arb.sv
// svc_fifo_wr_arb: round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
// Define SVC_FIFO_WR_ARB_TAG_EN to prefix each FIFO word with the granted requester index.
module svc_fifo_wr_arb #(
    parameter int N_REQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST = 16,
    localparam int IDX_WIDTH = $clog2(N_REQ)
) (
    input logic clk,
    input logic rst_n,
    svc_fifo_wr_arb_if.slave bus
);
    localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state;
    logic [IDX_WIDTH-1:0] rr_ptr, lock_idx, rr_idx, grant, nxt_ptr, gidx;
    logic [CW-1:0] beat_cnt;
    logic [DATA_WIDTH-1:0] payload;
    logic grant_valid, xfer, cap_hit, burst_end;

    function automatic logic [IDX_WIDTH-1:0] wrap(input int v);
        return IDX_WIDTH'(v >= N_REQ ? v - N_REQ : v);
    endfunction

    // Descending scan so the last hit is the candidate closest to rr_ptr.
    always_comb begin
        rr_idx = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req_valid[wrap(int'(rr_ptr) + k)]) rr_idx = wrap(int'(rr_ptr) + k);
    end

    always_comb begin
        payload = bus.req_data[DATA_WIDTH-1:0];
        for (int i = 1; i < N_REQ; i++)
            if (grant == IDX_WIDTH'(i)) payload = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign grant = (state == LOCKED) ? lock_idx : rr_idx;
    assign nxt_ptr = wrap(int'(grant) + 1);
    assign grant_valid = rst_n && (state == LOCKED || |bus.req_valid);
    assign xfer = grant_valid && bus.req_valid[grant] && !bus.fifo_w_full;
    assign cap_hit = MAX_BURST != 0 && beat_cnt == CW'(MAX_BURST - 1);
    assign burst_end = xfer && (bus.req_last[grant] || cap_hit);
    assign gidx = rst_n ? grant : '0;

    assign bus.fifo_w_inc = xfer;
    assign bus.req_ready = xfer ? (N_REQ'(1) << grant) : '0;
    assign bus.grant_valid = grant_valid;
    assign bus.grant_idx = gidx;
`ifdef SVC_FIFO_WR_ARB_TAG_EN
    assign bus.fifo_w_data = {gidx, payload};
`else
    assign bus.fifo_w_data = payload;
`endif

    // A non-final beat always (re)locks: in LOCKED grant already equals lock_idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            lock_idx <= '0;
            beat_cnt <= '0;
        end else if (burst_end) begin
            state <= IDLE;
            rr_ptr <= nxt_ptr;
            beat_cnt <= '0;
        end else if (xfer) begin
            state <= LOCKED;
            lock_idx <= grant;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_svc_fifo_wr_arb.sv
// tb_svc_fifo_wr_arb: two arbiters (MAX_BURST 16 and 4) driven by queued requester sources
// and compared cycle by cycle against a behavioural grant/burst model.
module tb_svc_fifo_wr_arb;
    localparam int N = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    svc_fifo_wr_arb_if #(.N_REQ(N), .DATA_WIDTH(DW)) b0 ();
    svc_fifo_wr_arb_if #(.N_REQ(N), .DATA_WIDTH(DW)) b1 ();
    svc_fifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    svc_fifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    logic [N-1:0] v [2], l [2], held [2], rdy [2];
    logic [N*DW-1:0] d [2];
    logic full [2], inc [2], gv [2];
    logic [1:0] gi [2];
    logic [31:0] wd [2];

    assign b0.req_valid = v[0];
    assign b0.req_data = d[0];
    assign b0.req_last = l[0];
    assign b0.fifo_w_full = full[0];
    assign b1.req_valid = v[1];
    assign b1.req_data = d[1];
    assign b1.req_last = l[1];
    assign b1.fifo_w_full = full[1];
    assign rdy[0] = b0.req_ready;
    assign inc[0] = b0.fifo_w_inc;
    assign gv[0] = b0.grant_valid;
    assign gi[0] = b0.grant_idx;
    assign wd[0] = 32'(b0.fifo_w_data);
    assign rdy[1] = b1.req_ready;
    assign inc[1] = b1.fifo_w_inc;
    assign gv[1] = b1.grant_valid;
    assign gi[1] = b1.grant_idx;
    assign wd[1] = 32'(b1.fifo_w_data);

    // Sources hold {last, data} beats; model tracks owner (-1 = none), beats taken and next search start.
    logic [8:0] src [2*N][$];
    int owner [2], nb [2], ptr [2], eg [2];
    bit ex [2];
    int mb [2] = '{16, 4};
    logic [31:0] sig_e [2][$], sig_o [2][$], wr_o [2][$];
    int go = 100;
    int errors = 0;
    int checks = 0;

    function automatic int w(int i, int b);
`ifdef SVC_FIFO_WR_ARB_TAG_EN
        return (i << 16) | (i << DW) | (i * 16 + b);
`else
        return (i << 16) | (i * 16 + b);
`endif
    endfunction

    task automatic load(int m, int i, int n, int base);
        for (int k = 0; k < n; k++) src[m*N+i].push_back({k == n - 1, 8'(i * 16 + base + k)});
    endtask

    task automatic clear();
        for (int m = 0; m < 2; m++) begin
            sig_e[m].delete();
            sig_o[m].delete();
            wr_o[m].delete();
        end
    endtask

    task automatic step();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
                if (!held[m][i]) v[m][i] = src[m*N+i].size() > 0 && $urandom_range(99) < go;
                if (v[m][i]) {l[m][i], d[m][i*DW +: DW]} = src[m*N+i][0];
                else begin
                    l[m][i] = 1'($urandom);
                    d[m][i*DW +: DW] = DW'($urandom);
                end
            end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit gvx, x;
            int g, pay;
            gvx = 0;
            g = 0;
            if (rst_n) begin
                if (owner[m] >= 0) begin
                    gvx = 1;
                    g = owner[m];
                end else
                    for (int k = 0; k < N; k++)
                        if (!gvx && v[m][(ptr[m] + k) % N]) begin
                            gvx = 1;
                            g = (ptr[m] + k) % N;
                        end
            end
            x = gvx && v[m][g] && !full[m];
`ifdef SVC_FIFO_WR_ARB_TAG_EN
            pay = (g << DW) | int'(d[m][g*DW +: DW]);
`else
            pay = int'(d[m][g*DW +: DW]);
`endif
            sig_e[m].push_back({3'b0, gvx, 2'b0, 2'(gvx ? g : 0), 3'b0, x, 4'(x ? 1 << g : 0), 16'(x ? pay : 0)});
            sig_o[m].push_back({3'b0, gv[m], 2'b0, (gvx || !rst_n) ? gi[m] : 2'b0, 3'b0, inc[m], rdy[m], x ? wd[m][15:0] : 16'h0});
            if (inc[m] === 1'b1) wr_o[m].push_back((32'(gi[m]) << 16) | wd[m]);
            ex[m] = x;
            eg[m] = g;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                owner[m] = -1;
                nb[m] = 0;
                ptr[m] = 0;
            end else if (ex[m]) begin
                nb[m]++;
                if (l[m][eg[m]] || (mb[m] != 0 && nb[m] == mb[m])) begin
                    owner[m] = -1;
                    nb[m] = 0;
                    ptr[m] = (eg[m] + 1) % N;
                end else owner[m] = eg[m];
                void'(src[m*N+eg[m]].pop_front());
            end
            for (int i = 0; i < N; i++) held[m][i] = v[m][i] && !(ex[m] && eg[m] == i);
        end
        #1;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            ok = 1;
            for (int q = 0; q < 2 * N; q++) if (src[q].size() != 0) ok = 0;
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        bit ok;
        clear();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) load(m, i, 1, 0);
        repeat (3) step();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (sig_o[m][c] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_outputs m%0d c%0d: got %h expected 0", m, c, sig_o[m][c]);
                end
            end
        rst_n = 1'b1;
        step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (wr_o[m].size() != 1 || wr_o[m][0] !== w(0, 0)) begin
                errors++;
                $display("FAIL first_grant m%0d: got %h (n=%0d) expected %h", m, wr_o[m][0], wr_o[m].size(), w(0, 0));
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_drain: timeout");
        end
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < sig_e[m].size(); c++) begin
                checks++;
                if (sig_o[m][c] !== sig_e[m][c]) begin
                    errors++;
                    $display("FAIL reset_cycle m%0d c%0d: got %h expected %h", m, c, sig_o[m][c], sig_e[m][c]);
                end
            end
    endtask

    task automatic test_fairness();
        bit ok;
        int e[$];
        clear();
        for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) begin
            load(m, i, 1, 0);
            load(m, i, 1, 1);
        end
        drain(ok);
        e = '{w(0, 0), w(1, 0), w(2, 0), w(3, 0), w(0, 1), w(1, 1), w(2, 1), w(3, 1)};
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (!ok || sig_e[m].size() != 8 || wr_o[m].size() != 8) begin
                errors++;
                $display("FAIL fair_rate m%0d: got %0d writes in %0d cycles expected 8 in 8", m, wr_o[m].size(), sig_e[m].size());
            end else
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (wr_o[m][k] !== e[k]) begin
                        errors++;
                        $display("FAIL fair_order m%0d k%0d: got %h expected %h", m, k, wr_o[m][k], e[k]);
                    end
                end
            for (int c = 0; c < sig_e[m].size(); c++) begin
                checks++;
                if (sig_o[m][c] !== sig_e[m][c]) begin
                    errors++;
                    $display("FAIL fair_cycle m%0d c%0d: got %h expected %h", m, c, sig_o[m][c], sig_e[m][c]);
                end
            end
        end
    endtask

    task automatic test_lock();
        bit ok;
        int e[$];
        clear();
        load(0, 1, 1, 0);
        drain(ok);
        clear();
        load(0, 2, 5, 0);
        load(0, 0, 1, 0);
        load(0, 1, 1, 1);
        drain(ok);
        e = '{w(2, 0), w(2, 1), w(2, 2), w(2, 3), w(2, 4), w(0, 0), w(1, 1)};
        checks++;
        if (!ok || wr_o[0].size() != e.size()) begin
            errors++;
            $display("FAIL lock_count: got %0d writes expected %0d", wr_o[0].size(), e.size());
        end else
            for (int k = 0; k < e.size(); k++) begin
                checks++;
                if (wr_o[0][k] !== e[k]) begin
                    errors++;
                    $display("FAIL lock_order k%0d: got %h expected %h", k, wr_o[0][k], e[k]);
                end
            end
        for (int c = 0; c < sig_e[0].size(); c++) begin
            checks++;
            if (sig_o[0][c] !== sig_e[0][c]) begin
                errors++;
                $display("FAIL lock_cycle c%0d: got %h expected %h", c, sig_o[0][c], sig_e[0][c]);
            end
        end
    endtask

    task automatic test_full_stall();
        bit ok;
        int e [2][$];
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear();
        for (int m = 0; m < 2; m++) begin
            load(m, 0, 5, 0);
            load(m, 2, 1, 0);
        end
        repeat (2) step();
        full[0] = 1'b1;
        full[1] = 1'b1;
        repeat (4) step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (wr_o[m].size() != 2) begin
                errors++;
                $display("FAIL stall_writes m%0d: got %0d writes expected 2", m, wr_o[m].size());
            end
        end
        full[0] = 1'b0;
        full[1] = 1'b0;
        drain(ok);
        e[0] = '{w(0, 0), w(0, 1), w(0, 2), w(0, 3), w(0, 4), w(2, 0)};
        e[1] = '{w(0, 0), w(0, 1), w(0, 2), w(0, 3), w(2, 0), w(0, 4)};
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (!ok || wr_o[m].size() != 6) begin
                errors++;
                $display("FAIL stall_count m%0d: got %0d writes expected 6", m, wr_o[m].size());
            end else
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (wr_o[m][k] !== e[m][k]) begin
                        errors++;
                        $display("FAIL stall_order m%0d k%0d: got %h expected %h", m, k, wr_o[m][k], e[m][k]);
                    end
                end
            for (int c = 0; c < sig_e[m].size(); c++) begin
                checks++;
                if (sig_o[m][c] !== sig_e[m][c]) begin
                    errors++;
                    $display("FAIL stall_cycle m%0d c%0d: got %h expected %h", m, c, sig_o[m][c], sig_e[m][c]);
                end
            end
        end
    endtask

    task automatic test_forced_release();
        bit ok;
        int e[$];
        clear();
        load(1, 1, 6, 0);
        load(1, 3, 2, 0);
        drain(ok);
        e = '{w(1, 0), w(1, 1), w(1, 2), w(1, 3), w(3, 0), w(3, 1), w(1, 4), w(1, 5)};
        checks++;
        if (!ok || wr_o[1].size() != e.size()) begin
            errors++;
            $display("FAIL release_count: got %0d writes expected %0d", wr_o[1].size(), e.size());
        end else
            for (int k = 0; k < e.size(); k++) begin
                checks++;
                if (wr_o[1][k] !== e[k]) begin
                    errors++;
                    $display("FAIL release_order k%0d: got %h expected %h", k, wr_o[1][k], e[k]);
                end
            end
        for (int c = 0; c < sig_e[1].size(); c++) begin
            checks++;
            if (sig_o[1][c] !== sig_e[1][c]) begin
                errors++;
                $display("FAIL release_cycle c%0d: got %h expected %h", c, sig_o[1][c], sig_e[1][c]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int e[$];
        clear();
        load(0, 1, 1, 0);
        drain(ok);
        load(0, 2, 5, 0);
        repeat (2) step();
        load(0, 1, 1, 1);
        load(0, 3, 1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drain(ok);
        e = '{w(1, 0), w(2, 0), w(2, 1), w(1, 1), w(2, 2), w(2, 3), w(2, 4), w(3, 0)};
        checks++;
        if (!ok || wr_o[0].size() != e.size()) begin
            errors++;
            $display("FAIL midrst_count: got %0d writes expected %0d", wr_o[0].size(), e.size());
        end else
            for (int k = 0; k < e.size(); k++) begin
                checks++;
                if (wr_o[0][k] !== e[k]) begin
                    errors++;
                    $display("FAIL midrst_order k%0d: got %h expected %h", k, wr_o[0][k], e[k]);
                end
            end
        for (int c = 0; c < sig_e[0].size(); c++) begin
            checks++;
            if (sig_o[0][c] !== sig_e[0][c]) begin
                errors++;
                $display("FAIL midrst_cycle c%0d: got %h expected %h", c, sig_o[0][c], sig_e[0][c]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int total [2];
        clear();
        for (int m = 0; m < 2; m++) begin
            total[m] = 0;
            for (int i = 0; i < N; i++)
                for (int p = 0; p < 4; p++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) src[m*N+i].push_back({k == len - 1, 8'($urandom)});
                    total[m] += len;
                end
        end
        for (int c = 0; c < 400; c++) begin
            go = 60;
            full[0] = $urandom_range(99) < 25;
            full[1] = $urandom_range(99) < 25;
            step();
        end
        go = 100;
        full[0] = 1'b0;
        full[1] = 1'b0;
        drain(ok);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (!ok || wr_o[m].size() != total[m]) begin
                errors++;
                $display("FAIL rand_count m%0d: got %0d writes expected %0d", m, wr_o[m].size(), total[m]);
            end
            for (int c = 0; c < sig_e[m].size(); c++) begin
                checks++;
                if (sig_o[m][c] !== sig_e[m][c]) begin
                    errors++;
                    $display("FAIL rand_cycle m%0d c%0d: got %h expected %h", m, c, sig_o[m][c], sig_e[m][c]);
                end
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            v[m] = '0;
            l[m] = '0;
            d[m] = '0;
            held[m] = '0;
            full[m] = 1'b0;
            owner[m] = -1;
            nb[m] = 0;
            ptr[m] = 0;
        end
        test_reset();
        test_fairness();
        test_lock();
        test_full_stall();
        test_forced_release();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
